// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file fed by the write-back stage.
// Holds NUM_REGS general-purpose registers of DATA_W bits. Writes commit on the
// rising clock edge. The two decode source-operand reads are combinational.
// Optional feature macro: WB_REGFILE_BYPASS_EN
//   defined   -> a matching write-back value is forwarded to the read ports in
//                the same cycle, which removes the WB->ID hazard.
//   undefined -> reads always return the stored register contents.
// Reset (rst) is asynchronous and active-high. It clears all registers and
// forces both read ports to zero while it is held.

module wb_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  read1RegSel,
  input  logic [SEL_W-1:0]  read2RegSel,
  input  logic [SEL_W-1:0]  writeRegSel,
  input  logic [DATA_W-1:0] writeData,
  input  logic              writeEn,
  output logic [DATA_W-1:0] read1Data,
  output logic [DATA_W-1:0] read2Data,
  output logic              err
);

  logic [DATA_W-1:0] regFile_r [NUM_REGS];
  logic              bypassEn_s;
  logic              read1Hit_s;
  logic              read2Hit_s;

  // Resolve one read port: forwarded write-back value on a hit, else stored data.
  function automatic logic [DATA_W-1:0] resolveRead(
    input logic              hit,
    input logic [DATA_W-1:0] fwdData,
    input logic [DATA_W-1:0] storedData
  );
    logic [DATA_W-1:0] result;
    if (hit) begin
      result = fwdData;
    end else begin
      result = storedData;
    end
    return result;
  endfunction

`ifdef WB_REGFILE_BYPASS_EN
  // Forwarding is qualified by the write enable and gated off during reset.
  assign bypassEn_s = writeEn & ~rst;
`else
  // Stored-contents-only build: the forwarding path is never taken.
  assign bypassEn_s = 1'b0;
`endif

  assign read1Hit_s = bypassEn_s && (read1RegSel == writeRegSel);
  assign read2Hit_s = bypassEn_s && (read2RegSel == writeRegSel);

  // Register storage: async clear on rst, single-register commit on writeEn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile_r[i] <= {DATA_W{1'b0}};
      end
    end else if (writeEn) begin
      regFile_r[writeRegSel] <= writeData;
    end else begin
      regFile_r <= regFile_r;
    end
  end

  // Read port 1: forced to zero in reset, otherwise bypassed or stored value.
  always_comb begin
    read1Data = {DATA_W{1'b0}};
    if (rst) begin
      read1Data = {DATA_W{1'b0}};
    end else begin
      read1Data = resolveRead(read1Hit_s, writeData, regFile_r[read1RegSel]);
    end
  end

  // Read port 2: same rules as port 1, checked independently.
  always_comb begin
    read2Data = {DATA_W{1'b0}};
    if (rst) begin
      read2Data = {DATA_W{1'b0}};
    end else begin
      read2Data = resolveRead(read2Hit_s, writeData, regFile_r[read2RegSel]);
    end
  end

  // This block has no error sources; the flag is tied low.
  assign err = 1'b0;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile. The stimulus side computes each expected
// read pair from an array model of the register file and pushes it into a queue.
// A monitor pops and compares the entries at the falling clock edge, or at
// once when an asynchronous-reset check is signalled.
// Define WB_REGFILE_BYPASS_EN for both bench and RTL to check the bypass build.

module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [2:0]  read1RegSel;
  logic [2:0]  read2RegSel;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic [15:0] read1Data;
  logic [15:0] read2Data;
  logic        err;

  typedef struct {
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic [2:0]  sel1;
    logic [2:0]  sel2;
    string       tag;
  } expect_t;

  expect_t     scoreQ[$];
  logic [15:0] model [8];
  int          checks;
  int          errors;
  event        checkEv;

  wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .err         (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Value a read port must show right now: zero in reset, the write-back value
  // on a bypass match, otherwise whatever the model array holds.
  function automatic logic [15:0] expRead(input logic [2:0] sel);
    if (rst) return 16'h0000;
`ifdef WB_REGFILE_BYPASS_EN
    if (writeEn && sel == writeRegSel) return writeData;
`endif
    return model[sel];
  endfunction

  task automatic pushExpect(input string tag);
    expect_t e;
    e.exp1 = expRead(read1RegSel);
    e.exp2 = expRead(read2RegSel);
    e.sel1 = read1RegSel;
    e.sel2 = read2RegSel;
    e.tag  = tag;
    scoreQ.push_back(e);
  endtask

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic we, input logic [2:0] ws, input logic [15:0] wd,
                       input logic [2:0] s1, input logic [2:0] s2, input string tag);
    writeEn     = we;
    writeRegSel = ws;
    writeData   = wd;
    read1RegSel = s1;
    read2RegSel = s2;
    #1;
    pushExpect(tag);
    @(posedge clk);
    if (we && !rst) model[ws] = wd;
    #1;
  endtask

  // Assert rst mid-cycle, check all registers read zero before any edge, then
  // hold a colliding write across an edge and release rst.
  task automatic resetPulse(input string tag);
    writeEn = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    for (int p = 0; p < 4; p++) begin
      read1RegSel = 3'(2 * p);
      read2RegSel = 3'(2 * p + 1);
      #1;
      pushExpect(tag);
      -> checkEv;
    end
    writeEn     = 1'b1;
    writeRegSel = 3'd7;
    writeData   = 16'h7777;
    read1RegSel = 3'd7;
    read2RegSel = 3'd7;
    #1;
    pushExpect({tag, "_bypassGated"});
    -> checkEv;
    @(posedge clk);
    #1;
    writeEn = 1'b0;
    rst     = 1'b0;
  endtask

  // Monitor: drain the scoreboard and compare against the DUT outputs.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk or checkEv);
      while (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        checks++;
        if (read1Data !== e.exp1) begin
          errors++;
          $display("FAIL %s read1 sel=%0d got=%h expected=%h", e.tag, e.sel1, read1Data, e.exp1);
        end
        checks++;
        if (read2Data !== e.exp2) begin
          errors++;
          $display("FAIL %s read2 sel=%0d got=%h expected=%h", e.tag, e.sel2, read2Data, e.exp2);
        end
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL %s err got=%b expected=0", e.tag, err);
        end
      end
    end
  end

  // Watchdog: the run must always reach its summary line.
  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL watchdog time limit reached, got=timeout expected=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [2:0]  ws;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [15:0] wd;
    logic        we;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    writeEn = 1'b0;
    writeRegSel = 3'd0;
    writeData = 16'h0000;
    read1RegSel = 3'd0;
    read2RegSel = 3'd7;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    #1;
    pushExpect("powerOnReset");
    -> checkEv;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state of every register.
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), "resetState");

    // Basic write/read.
    cycle(1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd1, "writeR3");
    cycle(1'b1, 3'd5, 16'h1234, 3'd2, 3'd4, "writeR5");
    cycle(1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, "readR3R5");
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 16'h0000, 3'(2 * i), 3'(2 * i + 1), "othersZero");

    // Write disable.
    cycle(1'b1, 3'd2, 16'h0022, 3'd2, 3'd3, "writeR2");
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd2, 16'hFFFF, 3'd2, 3'd2, "writeDisable");
    cycle(1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, "afterDisable");

    // Same-cycle WB->ID hazard.
    cycle(1'b1, 3'd4, 16'h0001, 3'd0, 3'd1, "hazardSetup");
    cycle(1'b1, 3'd4, 16'hA5A5, 3'd4, 3'd4, "hazardSameCycle");
    cycle(1'b0, 3'd4, 16'h0000, 3'd4, 3'd4, "hazardAfterEdge");
    cycle(1'b1, 3'd6, 16'h5A5A, 3'd6, 3'd1, "bypassPort1Only");
    cycle(1'b1, 3'd1, 16'h0F0F, 3'd6, 3'd1, "bypassPort2Only");

    // Full sweep.
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 3'(i), 3'(7 - i), "sweepWrite");
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), "sweepRead");

    // Asynchronous reset mid-cycle colliding with a write to R7.
    resetPulse("resetCollision");
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd7, 16'h7777, 3'(i), 3'(7 - i), "afterReset");
    cycle(1'b1, 3'd7, 16'hCAFE, 3'd0, 3'd1, "firstWriteAfterReset");
    cycle(1'b0, 3'd0, 16'h0000, 3'd7, 3'd7, "readFirstWrite");

    // Randomized traffic, biased towards read/write select collisions.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      ws = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      s1 = ($urandom_range(0, 3) == 0) ? ws : 3'($urandom_range(0, 7));
      s2 = ($urandom_range(0, 3) == 0) ? ws : 3'($urandom_range(0, 7));
      cycle(we, ws, wd, s1, s2, "random");
    end
    resetPulse("randomReset");
    for (int n = 0; n < 40; n++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "randomPostReset");
    end

    // Let the monitor drain the last entries, then confirm nothing was left over.
    for (int k = 0; k < 4 && scoreQ.size() > 0; k++) @(posedge clk);
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboardDrain got=%0d pending expected=0", scoreQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
